// File: rtl/dm_arbiter_if.sv
// Port bundle for the data-memory arbiter: CPU M-stage port, DMA beat port, DM port.
// Latency: none, wires only. Backpressure: cpu_stall / dma_gnt flow back to the masters.
// The requesting side uses master; the arbiter uses slave.
interface dm_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [3:0]  cpu_be;
  logic        cpu_stall;
  logic [31:0] cpu_rd;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wd;
  logic [3:0]  dma_be;
  logic        dma_last;
  logic        dma_gnt;
  logic [31:0] dma_rd;
  logic        dma_err;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [3:0]  mem_be;
  logic [31:0] mem_rd;

  logic        owner;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_be,
    output dma_req, dma_we, dma_addr, dma_wd, dma_be, dma_last,
    output mem_rd,
    input  cpu_stall, cpu_rd, dma_gnt, dma_rd, dma_err,
    input  mem_we, mem_addr, mem_wd, mem_be, owner
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_be,
    input  dma_req, dma_we, dma_addr, dma_wd, dma_be, dma_last,
    input  mem_rd,
    output cpu_stall, cpu_rd, dma_gnt, dma_rd, dma_err,
    output mem_we, mem_addr, mem_wd, mem_be, owner
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-master (CPU M-stage / DMA) arbiter for the single-ported DM; DMA aging under DM_ARB_AGING_EN.
// Latency: zero, grant/stall/mux are combinational in the request cycle; state moves on the edge.
// Backpressure: CPU frozen via cpu_stall, DMA beats held by its master until dma_gnt.
module dm_arbiter #(
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter logic [31:0] DM_TOP    = 32'h2fff
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_nxt;

  logic        preempt;
  logic        dma_win;
  logic        cpu_win;
  logic        dma_bad;

  logic        mem_we_c;
  logic [31:0] mem_addr_c;
  logic [31:0] mem_wd_c;
  logic [3:0]  mem_be_c;

`ifdef DM_ARB_AGING_EN
  localparam int unsigned WAIT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  // Counts consecutive denied cycles of a pending DMA beat; any grant or idle cycle restarts it.
  always_comb begin
    wait_nxt = wait_cnt;
    if (!bus.dma_req || dma_win) begin
      wait_nxt = '0;
    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_nxt = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_nxt;
    end
  end

  assign preempt = (wait_cnt == WAIT_W'(MAX_WAIT));
`else
  assign preempt = 1'b0;
`endif

  assign dma_bad = (bus.dma_addr > DM_TOP) || (bus.dma_addr[1:0] != 2'b00);

  always_comb begin
    dma_win = 1'b0;
    cpu_win = 1'b0;
    if (!reset) begin
      if (state == S_DMA) begin
        dma_win = bus.dma_req;
      end else begin
        dma_win = bus.dma_req & (~bus.cpu_req | preempt);
        cpu_win = bus.cpu_req & ~dma_win;
      end
    end
  end

  // Idle cycles park the address on the CPU side so the DM read path stays CPU-facing.
  always_comb begin
    mem_we_c   = cpu_win & bus.cpu_we;
    mem_addr_c = bus.cpu_addr;
    mem_wd_c   = bus.cpu_wd;
    mem_be_c   = bus.cpu_be;
    if (dma_win) begin
      mem_we_c   = bus.dma_we & ~dma_bad;
      mem_addr_c = bus.dma_addr;
      mem_wd_c   = bus.dma_wd;
      mem_be_c   = bus.dma_be;
    end
  end

  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wd    = mem_wd_c;
  assign bus.mem_be    = mem_be_c;
  assign bus.cpu_rd    = bus.mem_rd;
  assign bus.dma_rd    = bus.mem_rd;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_win & ~reset;
  assign bus.dma_gnt   = dma_win;
  assign bus.dma_err   = dma_win & dma_bad;
  assign bus.owner     = (state == S_DMA);

  // beat_cnt is only non-zero while the DMA owns the memory; illegal beats count too.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    case (state)
      S_CPU: begin
        beat_nxt = '0;
        if (dma_win && !bus.dma_last && (MAX_BURST > 1)) begin
          state_nxt = S_DMA;
          beat_nxt  = BEAT_W'(1);
        end
      end
      S_DMA: begin
        if (!bus.dma_req) begin
          state_nxt = S_CPU;
          beat_nxt  = '0;
        end else if (bus.dma_last || (beat_cnt + 1'b1 == BEAT_W'(MAX_BURST))) begin
          state_nxt = S_CPU;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_CPU;
        beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_CPU;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, hand-written multi-cycle sequences,
// and constrained-random traffic checked against a rule-level reference model.
module tb_dm_arbiter;
  localparam int          MAX_WAIT  = 8;
  localparam int          MAX_BURST = 16;
  localparam logic [31:0] DM_TOP    = 32'h2fff;
`ifdef DM_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_arbiter_if bus ();

  dm_arbiter #(
    .MAX_WAIT  (MAX_WAIT),
    .MAX_BURST (MAX_BURST),
    .DM_TOP    (DM_TOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // DM: 3072 words, asynchronous read, write on the rising edge.
  bit [31:0] dm      [0:3071];
  bit [31:0] ref_mem [0:3071];

  assign bus.mem_rd = (bus.mem_addr <= DM_TOP) ? dm[bus.mem_addr[13:2]] : 32'hdead_beef;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1 && bus.mem_addr <= DM_TOP) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_be[b]) dm[bus.mem_addr[13:2]][8*b +: 8] <= bus.mem_wd[8*b +: 8];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_on = 1'b0;
  bit m_owns;
  int m_denied;
  int m_beats;
  bit e_dma, e_cpu, e_bad;
  bit last_stall, last_gnt;

  function automatic int widx(logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  task automatic ref_write(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    if (a <= DM_TOP) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic predict();
    e_bad = (bus.dma_addr > DM_TOP) || (bus.dma_addr % 4 != 0);
    e_dma = 1'b0;
    e_cpu = 1'b0;
    if (!reset) begin
      if (m_owns) begin
        e_dma = bus.dma_req;
      end else begin
        e_dma = bus.dma_req && (!bus.cpu_req || (AGING && m_denied >= MAX_WAIT));
        e_cpu = bus.cpu_req && !e_dma;
      end
    end
  endtask

  task automatic model_check();
    predict();
    chk("cpu_stall", bus.cpu_stall, !reset && bus.cpu_req && !e_cpu);
    chk("dma_gnt", bus.dma_gnt, e_dma);
    chk("dma_err", bus.dma_err, e_dma && e_bad);
    chk("mem_we", bus.mem_we, (e_dma && bus.dma_we && !e_bad) || (e_cpu && bus.cpu_we));
    chk("owner", bus.owner, m_owns);
    if (e_dma) begin
      chk("mem_addr.dma", bus.mem_addr, bus.dma_addr);
      chk("mem_wd.dma", bus.mem_wd, bus.dma_wd);
      chk("mem_be.dma", bus.mem_be, bus.dma_be);
      if (!bus.dma_we && !e_bad) chk("dma_rd", bus.dma_rd, ref_mem[widx(bus.dma_addr)]);
    end else if (!reset) begin
      chk("mem_addr.cpu", bus.mem_addr, bus.cpu_addr);
    end
    if (e_cpu) begin
      chk("mem_wd.cpu", bus.mem_wd, bus.cpu_wd);
      chk("mem_be.cpu", bus.mem_be, bus.cpu_be);
      if (!bus.cpu_we && bus.cpu_addr <= DM_TOP)
        chk("cpu_rd", bus.cpu_rd, ref_mem[widx(bus.cpu_addr)]);
    end
  endtask

  task automatic model_update();
    predict();
    if (reset) begin
      m_owns = 1'b0; m_denied = 0; m_beats = 0;
      return;
    end
    if (bus.dma_req && !e_dma) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
    else m_denied = 0;
    if (e_dma) begin
      m_beats++;
      if (bus.dma_last || m_beats == MAX_BURST) begin
        m_owns = 1'b0; m_beats = 0;
      end else begin
        m_owns = 1'b1;
      end
      if (bus.dma_we && !e_bad) ref_write(bus.dma_addr, bus.dma_wd, bus.dma_be);
    end else begin
      if (m_owns) begin
        m_owns = 1'b0; m_beats = 0;
      end
      if (e_cpu && bus.cpu_we) ref_write(bus.cpu_addr, bus.cpu_wd, bus.cpu_be);
    end
  endtask

  task automatic half_check();
    @(negedge clk);
    if (m_on) model_check();
    last_stall = bus.cpu_stall;
    last_gnt   = bus.dma_gnt;
  endtask

  task automatic half_commit();
    @(posedge clk);
    if (m_on) model_update();
    #1;
  endtask

  task automatic cpu_set(bit req, bit we, logic [31:0] a, logic [31:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wd = d; bus.cpu_be = 4'hf;
  endtask

  task automatic dma_set(bit req, bit we, logic [31:0] a, logic [31:0] d, bit last);
    bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wd = d;
    bus.dma_be = 4'hf; bus.dma_last = last;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    bit          creq, cwe;
    logic [31:0] caddr, cwd;
    bit          dreq, dwe, dlast;
    logic [31:0] daddr, dwd;
    bit          x_stall, x_gnt, x_err, x_we, x_own, chk_rd;
    logic [31:0] x_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(bit creq, bit cwe, logic [31:0] caddr, logic [31:0] cwd,
                               bit dreq, bit dwe, logic [31:0] daddr, logic [31:0] dwd, bit dlast,
                               bit xs, bit xg, bit xe, bit xw, bit xo, bit cr, logic [31:0] xr);
    vec_t v;
    v.rst = 1'b0; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.dlast = dlast;
    v.x_stall = xs; v.x_gnt = xg; v.x_err = xe; v.x_we = xw; v.x_own = xo;
    v.chk_rd = cr; v.x_rd = xr;
    return v;
  endfunction

  int first_gnt, n_gnt, n_stall, beat;
  bit stall_after, own16, own17;

  initial begin
    reset = 1'b1;
    cpu_set(1'b1, 1'b0, 32'h0, 32'h0);
    dma_set(1'b1, 1'b1, 32'h100, 32'h0, 1'b0);
    last_stall = 1'b0; last_gnt = 1'b0;
    m_owns = 1'b0; m_denied = 0; m_beats = 0;

    // Reset: combinational outputs forced low even with both masters requesting.
    half_check();
    chk("rst.dma_gnt", bus.dma_gnt, 1'b0);
    chk("rst.cpu_stall", bus.cpu_stall, 1'b0);
    chk("rst.dma_err", bus.dma_err, 1'b0);
    chk("rst.mem_we", bus.mem_we, 1'b0);
    half_commit();
    m_on = 1'b1;
    half_check();
    half_commit();
    reset = 1'b0;
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dma_set(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    half_check();
    chk("rst.owner", bus.owner, 1'b0);
    half_commit();

    //              creq cwe caddr    cwd            dreq dwe daddr     dwd           last  st g e we own rd  rdval
    tbl.push_back(mkv(0, 0, 32'h0,   32'h0,          1, 1, 32'h100,  32'hA0A0_0000, 0,   0, 1, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mkv(0, 0, 32'h0,   32'h0,          1, 1, 32'h104,  32'hA0A0_0001, 0,   0, 1, 0, 1, 1, 0, 32'h0));
    tbl.push_back(mkv(0, 0, 32'h0,   32'h0,          1, 1, 32'h108,  32'hA0A0_0002, 0,   0, 1, 0, 1, 1, 0, 32'h0));
    tbl.push_back(mkv(0, 0, 32'h0,   32'h0,          1, 1, 32'h10c,  32'hA0A0_0003, 1,   0, 1, 0, 1, 1, 0, 32'h0));
    tbl.push_back(mkv(0, 0, 32'h0,   32'h0,          0, 0, 32'h0,    32'h0,         0,   0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(0, 0, 32'h0,   32'h0,          1, 1, 32'h3000, 32'hBAD0_0000, 1,   0, 1, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(0, 0, 32'h0,   32'h0,          1, 1, 32'h102,  32'hBAD0_0001, 1,   0, 1, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(1, 0, 32'h100, 32'h0,          0, 0, 32'h0,    32'h0,         0,   0, 0, 0, 0, 0, 1, 32'hA0A0_0000));
    tbl.push_back(mkv(1, 0, 32'h10c, 32'h0,          0, 0, 32'h0,    32'h0,         0,   0, 0, 0, 0, 0, 1, 32'hA0A0_0003));
    tbl.push_back(mkv(1, 1, 32'h0,   32'h5EED_0000,  0, 0, 32'h0,    32'h0,         0,   0, 0, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mkv(1, 0, 32'h0,   32'h0,          1, 1, 32'h300,  32'hB0B0_0000, 1,   0, 0, 0, 0, 0, 1, 32'h5EED_0000));
    tbl.push_back(mkv(0, 0, 32'h0,   32'h0,          1, 1, 32'h300,  32'hB0B0_0000, 1,   0, 1, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mkv(1, 0, 32'h300, 32'h0,          0, 0, 32'h0,    32'h0,         0,   0, 0, 0, 0, 0, 1, 32'hB0B0_0000));
    tbl.push_back(mkv(0, 0, 32'h0,   32'h0,          1, 0, 32'h104,  32'h0,         1,   0, 1, 0, 0, 0, 1, 32'hA0A0_0001));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      cpu_set(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd);
      dma_set(tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, tbl[i].dwd, tbl[i].dlast);
      half_check();
      chk($sformatf("tbl%0d.cpu_stall", i), bus.cpu_stall, tbl[i].x_stall);
      chk($sformatf("tbl%0d.dma_gnt", i), bus.dma_gnt, tbl[i].x_gnt);
      chk($sformatf("tbl%0d.dma_err", i), bus.dma_err, tbl[i].x_err);
      chk($sformatf("tbl%0d.mem_we", i), bus.mem_we, tbl[i].x_we);
      chk($sformatf("tbl%0d.owner", i), bus.owner, tbl[i].x_own);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d.rd", i), bus.cpu_rd, tbl[i].x_rd);
      half_commit();
    end

    // Starvation: continuous CPU loads against a DMA burst without dma_last.
    first_gnt = 0; n_gnt = 0; n_stall = 0; beat = 0; stall_after = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      cpu_set(1'b1, 1'b0, 32'h0, 32'h0);
      dma_set(1'b1, 1'b1, 32'h400 + 32'(4 * beat), 32'hC000_0000 + 32'(beat), 1'b0);
      half_check();
      if (bus.dma_gnt) begin
        if (first_gnt == 0) first_gnt = c;
        n_gnt++;
        beat++;
      end
      if (bus.cpu_stall) n_stall++;
      if (c == MAX_WAIT + 1 + MAX_BURST) stall_after = bus.cpu_stall;
      half_commit();
    end
    chk("age.first_gnt", first_gnt, AGING ? MAX_WAIT + 1 : 0);
    chk("age.n_gnt", n_gnt, AGING ? MAX_BURST : 0);
    chk("age.n_stall", n_stall, AGING ? MAX_BURST : 0);
    chk("age.cpu_served_after_cap", stall_after, 1'b0);
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dma_set(1'b1, 1'b1, 32'h400 + 32'(4 * beat), 32'hC000_0000 + 32'(beat), 1'b1);
    half_check();
    chk("age.resume_on_cpu_idle", bus.dma_gnt, 1'b1);
    half_commit();

    // Burst cap with an idle CPU: 20 beats, only the 20th carries dma_last.
    n_gnt = 0; own16 = 1'b0; own17 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
      dma_set(1'b1, 1'b1, 32'h800 + 32'(4 * c), 32'hD000_0000 + 32'(c), c == 20);
      half_check();
      if (bus.dma_gnt) n_gnt++;
      if (c == MAX_BURST) own16 = bus.owner;
      if (c == MAX_BURST + 1) own17 = bus.owner;
      half_commit();
    end
    chk("cap.n_gnt", n_gnt, 20);
    chk("cap.owner_beat16", own16, 1'b1);
    chk("cap.owner_beat17", own17, 1'b0);

    // Reset in beat 3 of a burst.
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dma_set(1'b1, 1'b1, 32'h500, 32'hE000_0000, 1'b0);
    half_check(); half_commit();
    dma_set(1'b1, 1'b1, 32'h504, 32'hE000_0001, 1'b0);
    half_check(); half_commit();
    reset = 1'b1;
    cpu_set(1'b1, 1'b0, 32'h0, 32'h0);
    dma_set(1'b1, 1'b1, 32'h508, 32'hE000_0002, 1'b0);
    half_check();
    chk("midrst.dma_gnt", bus.dma_gnt, 1'b0);
    chk("midrst.cpu_stall", bus.cpu_stall, 1'b0);
    chk("midrst.mem_we", bus.mem_we, 1'b0);
    half_commit();
    reset = 1'b0;
    dma_set(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    half_check();
    chk("postrst.owner", bus.owner, 1'b0);
    chk("postrst.cpu_stall", bus.cpu_stall, 1'b0);
    chk("postrst.cpu_rd", bus.cpu_rd, 32'h5EED_0000);
    half_commit();
    cpu_set(1'b1, 1'b0, 32'h508, 32'h0);
    half_check();
    chk("postrst.no_write", bus.cpu_rd, 32'h0);
    half_commit();

    // Constrained-random traffic; masters honour the hold rules.
    for (int c = 0; c < 3000; c++) begin
      if (!last_stall) begin
        bus.cpu_req  = ($urandom % 10) < 6;
        bus.cpu_we   = $urandom % 2;
        bus.cpu_addr = 32'($urandom_range(0, 3071)) << 2;
        bus.cpu_wd   = $urandom;
        bus.cpu_be   = 4'($urandom);
      end
      if (!(bus.dma_req && !last_gnt)) begin
        bus.dma_req  = ($urandom % 10) < 7;
        bus.dma_we   = $urandom % 2;
        bus.dma_addr = 32'($urandom_range(0, 3071)) << 2;
        if ($urandom % 8 == 0) begin
          case ($urandom % 3)
            0:       bus.dma_addr = 32'h3000 + (32'($urandom_range(0, 255)) << 2);
            1:       bus.dma_addr = bus.dma_addr | 32'($urandom_range(1, 3));
            default: bus.dma_addr = 32'hffff_fff0;
          endcase
        end
        bus.dma_wd   = $urandom;
        bus.dma_be   = 4'($urandom);
        bus.dma_last = ($urandom % 6) == 0;
      end
      reset = ($urandom % 300) == 0;
      half_check();
      half_commit();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
